// File: rtl/sd_cmd_if.sv
`default_nettype none
// ============================================================================
//  Module   : sd_cmd_if
//  Purpose  : Host-sequencer / pad-side bundle for the SD command engine.
//  Revision : 1.0 - initial release
// ============================================================================
interface sd_cmd_if;
  logic        clkFall;
  logic        clkRise;
  logic        cmdStart;
  logic [5:0]  cmdIndex;
  logic [31:0] cmdArg;
  logic        respExpect;
  logic        sdCmdIn;
  logic        sdCmdOut;
  logic        sdCmdOe;
  logic        busy;
  logic        done;
  logic [5:0]  respIndex;
  logic [31:0] respArg;
  logic        respCrcErr;
  logic        respTimeout;

  modport master (
    output clkFall, clkRise, cmdStart, cmdIndex, cmdArg, respExpect, sdCmdIn,
    input  sdCmdOut, sdCmdOe, busy, done, respIndex, respArg, respCrcErr, respTimeout
  );

  modport slave (
    input  clkFall, clkRise, cmdStart, cmdIndex, cmdArg, respExpect, sdCmdIn,
    output sdCmdOut, sdCmdOe, busy, done, respIndex, respArg, respCrcErr, respTimeout
  );
endinterface
`default_nettype wire

// File: rtl/sd_cmd_engine.sv
`default_nettype none
// ============================================================================
//  Module   : sd_cmd_engine
//  Purpose  : Serialises SD command frames on CMD and captures 48-bit replies,
//             generating and checking CRC7 on the fly.
//  Revision : 1.0 - initial release
// ============================================================================
module sd_cmd_engine #(
  parameter int TIMEOUT = 64,
  parameter int NCC     = 8
) (
  input wire      clkIn,
  input wire      rst,
  sd_cmd_if.slave bus
);
  localparam int                c_TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
  localparam logic [c_TO_W-1:0] c_TO_MAX   = c_TO_W'(TIMEOUT);
  localparam logic [5:0]        c_NCC_LAST = 6'(NCC - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_WAIT = 3'd2,
    S_RECV = 3'd3,
    S_NCC  = 3'd4
  } state_t;

  state_t              r_state, w_stateNext;
  logic [39:0]         r_frame;
  logic                r_respExp;
  logic [6:0]          r_crc;
  logic [5:0]          r_cnt;
  logic [c_TO_W-1:0]   r_toCnt;
  logic [45:0]         r_rx;
  logic                r_out, r_oe, r_busy, r_done, r_crcErr, r_timeout;
  logic [5:0]          r_respIndex;
  logic [31:0]         r_respArg;
  logic                w_txBit;
  logic [46:0]         w_rxFull;

  function automatic logic [6:0] f_crc7(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Frame body for the first 40 bits, then the CRC register drains MSB first.
  always_comb begin
    w_txBit = 1'b1;
    if (r_cnt < 6'd40)      w_txBit = r_frame[39];
    else if (r_cnt < 6'd47) w_txBit = r_crc[6];
  end

  // Received bits 46..0; the start bit is implied by entry into RECV.
  assign w_rxFull = {r_rx, bus.sdCmdIn};

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: if (bus.cmdStart) w_stateNext = S_SEND;
      S_SEND: if (bus.clkFall && r_cnt == 6'd48) w_stateNext = r_respExp ? S_WAIT : S_NCC;
      S_WAIT: if (bus.clkRise) begin
                if (!bus.sdCmdIn)            w_stateNext = S_RECV;
                else if (r_toCnt == c_TO_LAST) w_stateNext = S_NCC;
              end
      S_RECV: if (bus.clkRise && r_cnt == 6'd47) w_stateNext = S_NCC;
      S_NCC:  if (bus.clkFall && r_cnt == c_NCC_LAST) w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      r_frame <= '0; r_respExp <= 1'b0; r_crc <= '0; r_cnt <= '0; r_toCnt <= '0; r_rx <= '0;
      r_out <= 1'b1; r_oe <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0;
      r_crcErr <= 1'b0; r_timeout <= 1'b0; r_respIndex <= '0; r_respArg <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.cmdStart) begin
          r_frame   <= {2'b01, bus.cmdIndex, bus.cmdArg};
          r_respExp <= bus.respExpect;
          r_crc     <= '0;
          r_cnt     <= '0;
          r_toCnt   <= '0;
          r_crcErr  <= 1'b0;
          r_timeout <= 1'b0;
          r_busy    <= 1'b1;
        end
        S_SEND: if (bus.clkFall) begin
          if (r_cnt == 6'd48) begin
            r_oe    <= 1'b0;
            r_out   <= 1'b1;
            r_cnt   <= '0;
            r_crc   <= '0;
            r_toCnt <= '0;
          end else begin
            r_oe  <= 1'b1;
            r_out <= w_txBit;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt < 6'd40) begin
              r_crc   <= f_crc7(r_crc, w_txBit);
              r_frame <= {r_frame[38:0], 1'b0};
            end else if (r_cnt < 6'd47) begin
              r_crc <= {r_crc[5:0], 1'b0};
            end
          end
        end
        S_WAIT: if (bus.clkRise) begin
          if (!bus.sdCmdIn) begin
            r_cnt <= 6'd1;
          end else begin
            if (r_toCnt != c_TO_MAX) r_toCnt <= r_toCnt + c_TO_W'(1);
            if (r_toCnt == c_TO_LAST) begin
              r_timeout <= 1'b1;
              r_cnt     <= '0;
            end
          end
        end
        S_RECV: if (bus.clkRise) begin
          r_rx <= {r_rx[44:0], bus.sdCmdIn};
          if (r_cnt < 6'd40) r_crc <= f_crc7(r_crc, bus.sdCmdIn);
          if (r_cnt == 6'd47) begin
            r_respIndex <= w_rxFull[45:40];
            r_respArg   <= w_rxFull[39:8];
            r_crcErr    <= (w_rxFull[7:1] != r_crc) | w_rxFull[46] | ~w_rxFull[0];
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_NCC: if (bus.clkFall) begin
          if (r_cnt == c_NCC_LAST) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sdCmdOut    = r_out;
  assign bus.sdCmdOe     = r_oe;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.respIndex   = r_respIndex;
  assign bus.respArg     = r_respArg;
  assign bus.respCrcErr  = r_crcErr;
  assign bus.respTimeout = r_timeout;
endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_cmd_engine
//  Purpose  : Scoreboard bench for sd_cmd_engine with a CMD-line card model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_engine;
  localparam int c_NCC = 8;

  typedef struct {
    bit        hasResp;
    bit        crcErr;
    bit        tmo;
    bit [5:0]  idx;
    bit [31:0] arg;
    bit        chkGap;
  } exp_t;

  logic clkIn = 1'b0;
  logic rst   = 1'b1;
  sd_cmd_if bus ();

  sd_cmd_engine #(.TIMEOUT(64), .NCC(c_NCC)) dut (
    .clkIn (clkIn),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 clkIn = ~clkIn;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [47:0] q_frame[$];
  exp_t        q_res[$];
  bit          cardActive = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic logic [47:0] resp_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b00, idx, arg, crc7_ref({2'b00, idx, arg}), 1'b1};
  endfunction

  // SD clock strobes: one system cycle wide, fall and rise half a period apart.
  initial begin
    logic [1:0] ph;
    ph = 2'd3;
    bus.clkFall = 1'b0;
    bus.clkRise = 1'b0;
    forever begin
      @(posedge clkIn);
      #1;
      ph = ph + 2'd1;
      bus.clkFall = (ph == 2'd0);
      bus.clkRise = (ph == 2'd2);
    end
  end

  // Transmit monitor: a bit is valid on CMD the cycle after each clkFall.
  int          txBits = 0;
  logic [47:0] txShift;
  bit          prevFall = 1'b0;
  int          gap = 0;
  always @(negedge clkIn) begin
    logic [47:0] ef;
    exp_t        e;
    if (rst) begin
      txBits = 0;
      gap    = 0;
    end else begin
      if (prevFall && bus.sdCmdOe) begin
        txShift = {txShift[46:0], bus.sdCmdOut};
        txBits++;
        if (txBits == 48) begin
          txBits = 0;
          if (q_frame.size() == 0) check("frame_unexpected", txShift, 48'h0);
          else begin
            ef = q_frame.pop_front();
            check("frame", txShift, ef);
          end
        end
      end
      if (bus.sdCmdOe || cardActive) gap = 0;
      else if (bus.clkFall) gap++;
      if (bus.done) begin
        if (q_res.size() == 0) check("done_unexpected", 64'd1, 64'd0);
        else begin
          e = q_res.pop_front();
          check("respCrcErr", bus.respCrcErr, e.crcErr);
          check("respTimeout", bus.respTimeout, e.tmo);
          if (e.hasResp) begin
            check("respIndex", bus.respIndex, e.idx);
            check("respArg", bus.respArg, e.arg);
          end
          if (e.chkGap) check("ncc_gap", gap, c_NCC);
          check("busy_at_done", bus.busy, 1'b0);
        end
      end
    end
    prevFall = bus.clkFall;
  end

  task automatic wait_idle();
    bit ok;
    ok = !bus.busy;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(posedge clkIn); #1;
      if (!bus.busy) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_oe(input logic val);
    bit ok;
    ok = (bus.sdCmdOe === val);
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clkIn); #1;
      if (bus.sdCmdOe === val) ok = 1'b1;
    end
    if (!ok) check("oe_timeout", bus.sdCmdOe, val);
  endtask

  // Returns just after a clkFall strobe is seen by the DUT.
  task automatic wait_fall();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clkIn);
      if (bus.clkFall) ok = 1'b1;
    end
    #2;
    if (!ok) check("fall_timeout", 64'd1, 64'd0);
  endtask

  // mode: 0 no response, 1 good reply, 2 corrupted reply, 3 silent card
  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input int mode,
                         input logic [47:0] frame, input logic [47:0] reply, input bit midPulse);
    exp_t e;
    wait_idle();
    e.hasResp = (mode == 1 || mode == 2);
    e.crcErr  = (mode == 2);
    e.tmo     = (mode == 3);
    e.idx     = reply[45:40];
    e.arg     = reply[39:8];
    e.chkGap  = (mode != 3);
    q_frame.push_back(frame);
    q_res.push_back(e);
    bus.cmdIndex   = idx;
    bus.cmdArg     = arg;
    bus.respExpect = (mode != 0);
    bus.cmdStart   = 1'b1;
    @(posedge clkIn); #1;
    bus.cmdStart   = 1'b0;
    if (midPulse) begin
      repeat (40) @(posedge clkIn);
      #1;
      bus.cmdIndex   = ~idx;
      bus.cmdArg     = $urandom;
      bus.respExpect = ~bus.respExpect;
      bus.cmdStart   = 1'b1;
      @(posedge clkIn); #1;
      bus.cmdStart   = 1'b0;
    end
    if (mode == 1 || mode == 2) begin
      wait_oe(1'b1);
      wait_oe(1'b0);
      wait_fall();
      wait_fall();
      cardActive = 1'b1;
      for (int i = 47; i >= 0; i--) begin
        wait_fall();
        bus.sdCmdIn = reply[i];
      end
      cardActive = 1'b0;
      wait_fall();
      bus.sdCmdIn = 1'b1;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] rep;
    logic [5:0]  idx;
    logic [31:0] arg;
    int          mode, pos;
    int          flipPos[9];
    flipPos = '{1, 2, 3, 4, 5, 6, 7, 46, 0};

    bus.cmdStart = 1'b0; bus.cmdIndex = '0; bus.cmdArg = '0;
    bus.respExpect = 1'b0; bus.sdCmdIn = 1'b1;
    repeat (4) @(posedge clkIn);
    #1;
    check("rst_sdCmdOut", bus.sdCmdOut, 1'b1);
    check("rst_sdCmdOe", bus.sdCmdOe, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_resp", {bus.respIndex, bus.respArg, bus.respCrcErr, bus.respTimeout}, 64'd0);
    rst = 1'b0;
    repeat (3) @(posedge clkIn);
    #1;

    // CMD0, no response
    run_txn(6'd0, 32'h0, 0, 48'h40_0000_0000_95, 48'h0, 1'b0);
    // CMD8 with a correct R7-style reply
    run_txn(6'd8, 32'h1AA, 1, 48'h48_0000_01AA_87, 48'h08_0000_01AA_13, 1'b0);
    // CMD17 with one CRC bit flipped in the reply
    rep = resp_frame(6'd17, 32'h0000_0900) ^ 48'h4;
    run_txn(6'd17, 32'h0, 2, 48'h51_0000_0000_55, rep, 1'b0);
    // silent card
    run_txn(6'd55, 32'h0, 3, cmd_frame(6'd55, 32'h0), 48'h0, 1'b0);
    // stray cmdStart during SEND
    run_txn(6'd2, 32'hDEAD_BEEF, 0, cmd_frame(6'd2, 32'hDEAD_BEEF), 48'h0, 1'b1);

    // reset while the frame is going out
    wait_idle();
    bus.cmdIndex = 6'd9; bus.cmdArg = 32'h1234_5678; bus.respExpect = 1'b1;
    bus.cmdStart = 1'b1;
    @(posedge clkIn); #1;
    bus.cmdStart = 1'b0;
    repeat (30) @(posedge clkIn);
    #3 rst = 1'b1;
    #1;
    check("midrst_sdCmdOe", bus.sdCmdOe, 1'b0);
    check("midrst_sdCmdOut", bus.sdCmdOut, 1'b1);
    check("midrst_busy", bus.busy, 1'b0);
    @(posedge clkIn); #1;
    rst = 1'b0;
    @(posedge clkIn); #1;

    // random traffic, issued back-to-back as busy falls
    for (int n = 0; n < 24; n++) begin
      idx  = 6'($urandom_range(0, 63));
      arg  = $urandom;
      mode = $urandom_range(0, 3);
      rep  = resp_frame(6'($urandom_range(0, 63)), $urandom);
      if (mode == 2) begin
        pos = flipPos[$urandom_range(0, 8)];
        rep[pos] = ~rep[pos];
      end
      run_txn(idx, arg, mode, cmd_frame(idx, arg), rep, ($urandom_range(0, 5) == 0));
    end

    wait_idle();
    repeat (10) @(posedge clkIn);
    #1;
    check("frames_left", q_frame.size(), 0);
    check("results_left", q_res.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
